// File: rtl/cla_pkg.sv
// Shared constants and FSM state type for the sequential CLA subtractor.
// Optional signed-overflow output is enabled by CLA_SUB_SIGNED_OVF_EN.
package cla_pkg;

    localparam int CLA_WIDTH = 32;
    localparam int CLA_SLICE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_slices(input int width, input int slice);
        return width / slice;
    endfunction

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational carry-lookahead adder slice: s = x + y + cin.
// Every carry is a flat OR of generate/propagate product terms.
module cla_slice
    import cla_pkg::*;
#(
    parameter int W = CLA_SLICE
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic         term;
    logic         acc;

    assign g = x & y;
    assign p = x ^ y;

    // c[i+1] = cin&p[0..i] | OR_j g[j]&p[j+1..i], no carry chaining
    always_comb begin
        c    = '0;
        term = 1'b0;
        acc  = 1'b0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            term = cin;
            for (int k = 0; k <= i; k++) begin
                term = term & p[k];
            end
            acc = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                acc = acc | term;
            end
            c[i+1] = acc;
        end
    end

    assign s    = p ^ c[W-1:0];
    assign cout = c[W];

endmodule

// File: rtl/cla_sub_seq.sv
// Sequential subtractor: a - b resolved SLICE bits per cycle through one CLA slice.
// Define CLA_SUB_SIGNED_OVF_EN to add the signed-overflow output ovf.
module cla_sub_seq
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int SLICE = CLA_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
`ifdef CLA_SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSL = num_slices(WIDTH, SLICE);
    localparam int IW  = idx_bits(NSL);
    localparam logic [IW-1:0] LAST = IW'(NSL - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] nb_q;
    logic             carry;
    logic [IW-1:0]    idx;

    logic [SLICE-1:0] x_sl;
    logic [SLICE-1:0] y_sl;
    logic [SLICE-1:0] s_sl;
    logic             cout;
    logic [WIDTH-1:0] diff_nx;

    always_comb begin
        x_sl = a_q[int'(idx)*SLICE +: SLICE];
        y_sl = nb_q[int'(idx)*SLICE +: SLICE];
    end

    cla_slice #(
        .W (SLICE)
    ) u_slice (
        .x    (x_sl),
        .y    (y_sl),
        .cin  (carry),
        .s    (s_sl),
        .cout (cout)
    );

    // diff with the current slice already merged, so DONE flags see the final value
    always_comb begin
        diff_nx = diff;
        diff_nx[int'(idx)*SLICE +: SLICE] = s_sl;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            nb_q      <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            diff      <= '0;
            borrow    <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef CLA_SUB_SIGNED_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        nb_q     <= ~b;
                        carry    <= 1'b1;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    diff  <= diff_nx;
                    carry <= cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        borrow    <= ~cout;
                        zero      <= (diff_nx == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef CLA_SUB_SIGNED_OVF_EN
                        // nb_q holds ~b, so b's sign is its inverse
                        ovf <= (a_q[WIDTH-1] == nb_q[WIDTH-1]) &&
                               (diff_nx[WIDTH-1] != a_q[WIDTH-1]);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_sub_seq.sv
// Randomized self-checking bench for cla_sub_seq against an arithmetic model.
// Define CLA_SUB_SIGNED_OVF_EN to also check the ovf output.
module tb_cla_sub_seq;

    localparam int W   = 32;
    localparam int LAT = 5;
    localparam int GAP = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
`ifdef CLA_SUB_SIGNED_OVF_EN
    logic         ovf;
`endif

    int passed = 0;
    int total  = 0;

    cla_sub_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero)
`ifdef CLA_SUB_SIGNED_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operands
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  output logic [W-1:0] md, output logic mbo,
                                  output logic mz, output logic mo);
        longint sa;
        longint sb;
        longint r;
        md  = ma - mb;
        mbo = (ma < mb);
        mz  = (md == 0);
        sa  = longint'($signed(ma));
        sb  = longint'($signed(mb));
        r   = sa - sb;
        mo  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    // Drives one transaction; a/b are scrambled right after acceptance
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input int stall, output logic [W-1:0] od,
                         output logic ob, output logic oz, output logic oo,
                         output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        in_valid = 1'b1;
        a = ia;
        b = ib;
        tick();
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        repeat (stall) tick();
        od = diff;
        ob = borrow;
        oz = zero;
`ifdef CLA_SUB_SIGNED_OVF_EN
        oo = ovf;
`else
        oo = 1'b0;
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({in_ready, out_valid, borrow, zero} !== 4'b1000) begin
            $display("FAIL reset_flags got rdy/ov/bo/z=%b need 1000",
                     {in_ready, out_valid, borrow, zero});
        end else passed++;
        total++;
        if (diff !== '0) begin
            $display("FAIL reset_diff got %h need 0", diff);
        end else passed++;
        in_valid = 1'b1;
        a = 32'd9;
        b = 32'd4;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_prio got in_ready=%b need 1", in_ready);
        end else passed++;
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [8];
        logic [W-1:0] vb [8];
        logic [W-1:0] d;
        logic [W-1:0] ed;
        logic bo, z, o, ebo, ez, eo;
        int lat;
        va = '{32'd25, 32'd10, 32'd72, 32'd0,
               32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'h0000_00FF};
        vb = '{32'd10, 32'd25, 32'd72, 32'd1,
               32'hFFFF_FFFF, 32'd0, 32'd0, 32'h0000_0100};
        for (int i = 0; i < 8; i++) begin
            do_op(va[i], vb[i], 0, d, bo, z, o, lat);
            model(va[i], vb[i], ed, ebo, ez, eo);
            total++;
            if (lat !== LAT) begin
                $display("FAIL vec%0d_latency got %0d need %0d", i, lat, LAT);
            end else passed++;
            total++;
            if ({d, bo, z} !== {ed, ebo, ez}) begin
                $display("FAIL vec%0d_result got %h/%b/%b need %h/%b/%b",
                         i, d, bo, z, ed, ebo, ez);
            end else passed++;
        end
    endtask

    task automatic test_backpressure();
        int guard;
        int held_bad;
        guard = 0;
        held_bad = 0;
        in_valid = 1'b1;
        a = 32'd100;
        b = 32'd28;
        tick();
        in_valid = 1'b0;
        a = $urandom;
        while (!out_valid && guard < 20) begin
            tick();
            guard++;
        end
        for (int i = 0; i < 3; i++) begin
            if (!(out_valid === 1'b1 && diff === 32'd72 && in_ready === 1'b0))
                held_bad++;
            tick();
        end
        total++;
        if (held_bad != 0 || out_valid !== 1'b1) begin
            $display("FAIL stall_hold got %0d bad cycles, ov=%b diff=%0d need 0/1/72",
                     held_bad, out_valid, diff);
        end else passed++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            $display("FAIL stall_release got ov/rdy=%b need 01",
                     {out_valid, in_ready});
        end else passed++;
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] d;
        logic bo, z, o;
        int lat;
        int seen;
        seen = 0;
        in_valid = 1'b1;
        a = 32'd5;
        b = 32'd3;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1) begin
            $display("FAIL abort_ready got %b need 1", in_ready);
        end else passed++;
        for (int i = 0; i < 10; i++) begin
            if (out_valid === 1'b1) seen++;
            tick();
        end
        total++;
        if (seen != 0) begin
            $display("FAIL abort_no_valid got %0d pulses need 0", seen);
        end else passed++;
        do_op(32'd7, 32'd2, 0, d, bo, z, o, lat);
        total++;
        if ({d, bo, z} !== {32'd5, 1'b0, 1'b0} || lat != LAT) begin
            $display("FAIL abort_next got %0d/%b/%b lat %0d need 5/0/0 lat %0d",
                     d, bo, z, lat, LAT);
        end else passed++;
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, d, ed;
        logic bo, z, o, ebo, ez, eo;
        int lat;
        int bad;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? ra : W'($urandom);
            do_op(ra, rb, $urandom_range(0, 3), d, bo, z, o, lat);
            model(ra, rb, ed, ebo, ez, eo);
            total++;
            if ({d, bo, z} !== {ed, ebo, ez} || lat != LAT) begin
                $display("FAIL rand%0d got %h/%b/%b lat %0d need %h/%b/%b lat %0d",
                         i, d, bo, z, lat, ed, ebo, ez, LAT);
            end else passed++;
`ifdef CLA_SUB_SIGNED_OVF_EN
            total++;
            if (o !== eo) begin
                $display("FAIL rand%0d_ovf got %b need %b", i, o, eo);
            end else passed++;
`endif
        end
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$];
        logic [W:0] exp_q[$];
        logic [W-1:0] ed;
        logic [W:0] e;
        logic ebo, ez, eo;
        int gap_bad;
        gap_bad = 0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        a = $urandom;
        b = $urandom;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (cyc == 40) in_valid = 1'b0;
            if (in_valid && in_ready) begin
                acc_cyc.push_back(cyc);
                model(a, b, ed, ebo, ez, eo);
                exp_q.push_back({ebo, ed});
            end
            if (out_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_extra got diff %h need none", diff);
                end else begin
                    e = exp_q.pop_front();
                    if ({borrow, diff} !== e) begin
                        $display("FAIL b2b_result got %b/%h need %b/%h",
                                 borrow, diff, e[W], e[W-1:0]);
                    end else passed++;
                end
            end
            tick();
            a = $urandom;
            b = $urandom;
        end
        out_ready = 1'b0;
        for (int i = 1; i < acc_cyc.size(); i++) begin
            if (acc_cyc[i] - acc_cyc[i-1] != GAP) gap_bad++;
        end
        total++;
        if (gap_bad != 0 || acc_cyc.size() < 6 || exp_q.size() != 0) begin
            $display("FAIL b2b_spacing got %0d bad gaps, %0d accepts, %0d left need 0/>=6/0",
                     gap_bad, acc_cyc.size(), exp_q.size());
        end else passed++;
    endtask

`ifdef CLA_SUB_SIGNED_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] d;
        logic bo, z, o;
        int lat;
        do_op(32'h8000_0000, 32'd1, 0, d, bo, z, o, lat);
        total++;
        if ({d, o, bo} !== {32'h7FFF_FFFF, 1'b1, 1'b0}) begin
            $display("FAIL ovf_min got %h/%b/%b need 7fffffff/1/0", d, o, bo);
        end else passed++;
        do_op(32'd1, 32'd2, 0, d, bo, z, o, lat);
        total++;
        if (o !== 1'b0) begin
            $display("FAIL ovf_small got %b need 0", o);
        end else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_abort();
        test_random();
        test_back_to_back();
`ifdef CLA_SUB_SIGNED_OVF_EN
        test_ovf();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cla_sub_seq.md
CLA_SUB_SEQ -- requirements
Module: cla_sub_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter: SLICE, default 8, bits resolved per cycle; WIDTH SHALL be an integer multiple of SLICE.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand pair a/b is presented.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 a  input  WIDTH  minuend.
REQ-008 b  input  WIDTH  subtrahend.
REQ-009 out_valid  output  1  result fields are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-012 borrow  output  1  1 when unsigned a < b.
REQ-013 zero  output  1  1 when diff == 0.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-015 IDLE: in_ready = 1; in_valid=1 -> latch a and ~b, set carry = 1, clear slice index, go to RUN.
REQ-016 RUN: each cycle, SLICE bits at the current index SHALL be computed as a + ~b + carry by a carry-lookahead slice; sum bits are written into diff; carry-out is registered for the next slice.
REQ-017 RUN SHALL last exactly WIDTH/SLICE cycles (4 at defaults); after the last slice, go to DONE.
REQ-018 DONE: out_valid = 1; borrow = NOT(final carry-out); zero = (diff == 0).
REQ-019 DONE with out_ready=1 -> IDLE; out_ready=0 -> remain in DONE with diff/borrow/zero held stable.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored.
REQ-021 Latency: in_valid accepted in cycle N -> out_valid = 1 in cycle N + WIDTH/SLICE + 1.
REQ-022 Throughput: at most one operation per WIDTH/SLICE + 2 cycles; no back-to-back acceptance in the DONE->IDLE cycle.
REQ-023 Operands are registered at acceptance; changes on a/b after acceptance SHALL NOT affect the result.
REQ-024 a == b SHALL give diff = 0, borrow = 0, zero = 1; a = 0, b = 1 SHALL give diff = all ones, borrow = 1.

Reset
REQ-025 rst=1 SHALL force IDLE, and SHALL clear diff, carry, and slice index to 0; borrow = 0, zero = 0, out_valid = 0, in_ready = 1 in the cycle after reset.
REQ-026 rst asserted during RUN or DONE SHALL abort the operation; no out_valid pulse follows.
REQ-027 rst SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-028 Macro CLA_SUB_SIGNED_OVF_EN defined: add output ovf (1 bit) = signed two's-complement overflow, i.e. (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]); ovf is valid with out_valid and reset to 0.
REQ-029 Macro CLA_SUB_SIGNED_OVF_EN undefined: ovf port and its logic are absent; all other behaviour is identical.

Structure
REQ-030 Shared package cla_pkg SHALL hold the WIDTH/SLICE default constants and the FSM state typedef (IDLE, RUN, DONE).
REQ-031 Sub-module cla_slice SHALL be a combinational SLICE-bit carry-lookahead adder with ports x, y, cin, s, cout, instantiated once inside cla_sub_seq.

Verification
REQ-032 a=25, b=10, out_ready=1 -> after 5 cycles: diff=15, borrow=0, zero=0.
REQ-033 a=10, b=25 -> diff=0xFFFFFFF1, borrow=1, zero=0.
REQ-034 a=72, b=72 -> diff=0, borrow=0, zero=1.
REQ-035 a=100, b=28, out_ready held 0 for 3 cycles in DONE -> diff=72 stable and out_valid high throughout; in_ready=0 until the cycle after the handshake.
REQ-036 rst pulsed in the 2nd RUN cycle of a=5, b=3 -> no out_valid; the next operation a=7, b=2 returns diff=5.
REQ-037 With CLA_SUB_SIGNED_OVF_EN: a=0x80000000, b=1 -> diff=0x7FFFFFFF, ovf=1, borrow=0; a=1, b=2 -> ovf=0.
